// File: rtl/hamming74_stream_decoder.sv
// Hamming(7,4) stream decoder: corrects single-bit errors, flags a nonzero syndrome.
// Latency: two clk edges from input transfer to out_valid while the pipe advances.
// Backpressure: a stalled output freezes both stages; in_ready follows the global advance.
// Optional statistics counter is built only when HAM74_STATS_EN is defined;
// otherwise corr_cnt is tied to zero and cnt_clr is ignored.
module hamming74_stream_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_code,
    input  logic             corr_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic             out_err,
    output logic [2:0]       out_syn,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt
);

    // Both stages move as one; the pipe only stops when the sink refuses a valid word.
    logic       adv;
    logic [2:0] in_syn;

    // Stage 1 keeps only the data positions of the codeword: once the syndrome is
    // captured, the parity bits carry no further information for the data path.
    logic       s1_vld;
    logic [3:0] s1_data;
    logic [2:0] s1_syn;
    logic       s1_corr;

    logic [3:0] fix_data;
    logic       fix_err;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Syndrome bits: each one checks the code positions whose 1-based index has that bit set.
    always_comb begin
        in_syn    = 3'd0;
        in_syn[0] = in_code[0] ^ in_code[2] ^ in_code[4] ^ in_code[6];
        in_syn[1] = in_code[1] ^ in_code[2] ^ in_code[5] ^ in_code[6];
        in_syn[2] = in_code[3] ^ in_code[4] ^ in_code[5] ^ in_code[6];
    end

    // Stage 1: capture the word, its syndrome and the correction mode on every advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_data <= 4'd0;
            s1_syn  <= 3'd0;
            s1_corr <= 1'b0;
        end else if (adv) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_data <= {in_code[6], in_code[5], in_code[4], in_code[2]};
                s1_syn  <= in_syn;
                s1_corr <= corr_en;
            end
        end
    end

    // Correction: a syndrome naming a data position flips that bit; parity hits leave data alone.
    always_comb begin
        fix_data    = s1_data;
        fix_err     = (s1_syn != 3'd0);
        fix_data[0] = s1_data[0] ^ (s1_corr && (s1_syn == 3'd3));
        fix_data[1] = s1_data[1] ^ (s1_corr && (s1_syn == 3'd5));
        fix_data[2] = s1_data[2] ^ (s1_corr && (s1_syn == 3'd6));
        fix_data[3] = s1_data[3] ^ (s1_corr && (s1_syn == 3'd7));
    end

    // Stage 2: output register; a stage-1 bubble becomes out_valid=0 with data held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 4'd0;
            out_err   <= 1'b0;
            out_syn   <= 3'd0;
        end else if (adv) begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                out_data <= fix_data;
                out_err  <= fix_err;
                out_syn  <= s1_syn;
            end
        end
    end

`ifdef HAM74_STATS_EN
    logic [CNT_W-1:0] cnt_q;

    // Count delivered flagged words; saturate at all-ones, clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (out_valid && out_ready && out_err && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign corr_cnt = cnt_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign corr_cnt       = '0;
`endif

endmodule

// File: tb/tb_hamming74_stream_decoder.sv
// Self-checking bench for hamming74_stream_decoder.
// Directed table with latency checks, hand sequences for stall/saturation/reset,
// then randomized traffic against a position-XOR reference decoder and a word queue.
module tb_hamming74_stream_decoder;

    localparam int TB_CNT_W = 2;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;
`ifdef HAM74_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [6:0]          in_code;
    logic                corr_en;
    logic                out_valid;
    logic                out_ready;
    logic [3:0]          out_data;
    logic                out_err;
    logic [2:0]          out_syn;
    logic                cnt_clr;
    logic [TB_CNT_W-1:0] corr_cnt;

    int checks = 0;
    int errors = 0;
    int mcnt   = 0;
    logic [7:0] expq[$];

    typedef struct {
        logic [6:0] code;
        logic       en;
        logic [3:0] data;
        logic       err;
        logic [2:0] syn;
    } vec_t;

    vec_t tbl[11];

    hamming74_stream_decoder #(.CNT_W(TB_CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .corr_en   (corr_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_syn   (out_syn),
        .cnt_clr   (cnt_clr),
        .corr_cnt  (corr_cnt)
    );

    always #5 clk = ~clk;

    // Reference: the syndrome is the XOR of the 1-based positions of all set bits.
    function automatic logic [7:0] ref_decode(input logic [6:0] code, input logic en);
        int         syn;
        logic [6:0] c;
        logic [2:0] s3;
        syn = 0;
        c   = code;
        for (int i = 0; i < 7; i++)
            if (code[i]) syn = syn ^ (i + 1);
        if (syn != 0 && en) c[syn-1] = ~c[syn-1];
        s3 = syn[2:0];
        return {c[6], c[5], c[4], c[2], (syn != 0), s3};
    endfunction

    // Encoder: place data, then set parity bits 1,2,4 to cancel the data syndrome.
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] c;
        int         syn;
        c   = {d[3], d[2], d[1], 1'b0, d[0], 2'b00};
        syn = 0;
        for (int i = 0; i < 7; i++)
            if (c[i]) syn = syn ^ (i + 1);
        c[0] = syn[0];
        c[1] = syn[1];
        c[3] = syn[2];
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cyc(input logic iv, input logic [6:0] code, input logic en,
                       input logic ordy, input logic clr);
        logic in_fire;
        logic out_fire;
        logic exp_err;
        in_valid  = iv;
        in_code   = code;
        corr_en   = en;
        out_ready = ordy;
        cnt_clr   = clr;
        #1;
        chk("in_ready", in_ready, (!out_valid || ordy));
        chk("corr_cnt", corr_cnt, mcnt);
        exp_err = 1'b0;
        if (out_valid) begin
            if (expq.size() == 0) fail("spurious_out_valid");
            else begin
                chk("out_word", {out_data, out_err, out_syn}, expq[0]);
                exp_err = expq[0][3];
            end
        end
        in_fire  = iv && in_ready;
        out_fire = out_valid && ordy;
        if (STATS) begin
            if (clr) mcnt = 0;
            else if (out_fire && exp_err && mcnt < CNT_MAX) mcnt++;
        end
        if (out_fire && expq.size() > 0) void'(expq.pop_front());
        if (in_fire) expq.push_back(ref_decode(code, en));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((expq.size() != 0 || out_valid) && n < 20) begin
            cyc(1'b0, 7'd0, 1'b1, 1'b1, 1'b0);
            n++;
        end
        if (expq.size() != 0 || out_valid) fail(name);
        else chk({name, "_idle"}, out_valid, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] a, b, c, w;
        logic [6:0] bad;

        tbl[0]  = '{7'b1001011, 1'b1, 4'b1000, 1'b0, 3'd0};
        tbl[1]  = '{7'b1011011, 1'b1, 4'b1000, 1'b1, 3'd5};
        tbl[2]  = '{7'b1011011, 1'b0, 4'b1010, 1'b1, 3'd5};
        tbl[3]  = '{7'b0000000, 1'b1, 4'b0000, 1'b0, 3'd0};
        tbl[4]  = '{7'b0000001, 1'b1, 4'b0000, 1'b1, 3'd1};
        tbl[5]  = '{7'b1111111, 1'b1, 4'b1111, 1'b0, 3'd0};
        tbl[6]  = '{7'b1111110, 1'b1, 4'b1111, 1'b1, 3'd1};
        tbl[7]  = '{7'b0111111, 1'b1, 4'b1111, 1'b1, 3'd7};
        tbl[8]  = '{7'b0111111, 1'b0, 4'b0111, 1'b1, 3'd7};
        tbl[9]  = '{7'b1001000, 1'b1, 4'b1001, 1'b1, 3'd3};
        tbl[10] = '{7'b0111011, 1'b1, 4'b0110, 1'b1, 3'd4};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = 7'd0;
        corr_en   = 1'b1;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_word", {out_data, out_err, out_syn}, 8'd0);
        chk("rst_cnt", corr_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1'b1);

        // Directed table, one word at a time, checking two-edge latency.
        for (int i = 0; i < 11; i++) begin
            in_valid  = 1'b1;
            in_code   = tbl[i].code;
            corr_en   = tbl[i].en;
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            chk("lat_early", out_valid, 1'b0);
            @(posedge clk);
            @(negedge clk);
            chk("lat_valid", out_valid, 1'b1);
            chk("tbl_data", out_data, tbl[i].data);
            chk("tbl_err", out_err, tbl[i].err);
            chk("tbl_syn", out_syn, tbl[i].syn);
            if (STATS && tbl[i].err && mcnt < CNT_MAX) mcnt++;
            @(posedge clk);
            @(negedge clk);
            chk("tbl_cnt", corr_cnt, mcnt);
            chk("tbl_no_dup", out_valid, 1'b0);
        end

        // Clean stream, four back-to-back beats.
        cyc(1'b0, 7'd0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 7'b1001011, 1'b1, 1'b1, 1'b0);
        drain("clean_drain");

        // Saturation: five flagged words.
        for (int i = 0; i < 5; i++) cyc(1'b1, 7'b1011011, 1'b1, 1'b1, 1'b0);
        drain("sat_drain");
        chk("sat_value", corr_cnt, STATS ? CNT_MAX : 0);

        // Clear coinciding with a flagged transfer.
        cyc(1'b1, 7'b1011011, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 7'd0, 1'b1, 1'b1, 1'b1);
        chk("clr_wins", corr_cnt, 0);
        drain("clr_drain");

        // Backpressure: three words, sink stalled for five cycles.
        a = encode(4'b0011);
        b = encode(4'b1100);
        c = encode(4'b0101);
        cyc(1'b1, a, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, b, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", in_ready, 1'b0);
            cyc(1'b1, c, 1'b1, 1'b0, 1'b0);
        end
        cyc(1'b1, c, 1'b1, 1'b1, 1'b0);
        drain("bp_drain");

        // Randomized traffic with flow-control noise and occasional clears.
        for (int i = 0; i < 2000; i++) begin
            w = encode(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) != 0) begin
                bad = w;
                bad[$urandom_range(0, 6)] ^= 1'b1;
                if ($urandom_range(0, 7) == 0) bad[$urandom_range(0, 6)] ^= 1'b1;
                w = bad;
            end
            cyc(1'($urandom_range(0, 1)), w, ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
        end
        drain("rand_drain");

        // Reset with two words in flight.
        cyc(1'b1, 7'b1011011, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 7'b1001011, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_valid", out_valid, 1'b1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_word", {out_data, out_err, out_syn}, 8'd0);
        chk("mid_rst_cnt", corr_cnt, 0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        expq.delete();
        mcnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 7'd0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 7'b1011011, 1'b0, 1'b1, 1'b0);
        drain("post_rst_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
